// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// ---------------------------------------------------------------------------
// Sequencer for the 4-page CPU cache. Holds the per-page tag/valid array and
// true-LRU ages, resolves lookups from the cache datapath, and on a miss
// stalls the CPU (rdy low) while the victim page is burst-filled byte by byte
// from backing memory.
//
// Ports (all logic on the rising edge of fpga):
//   fpga            system clock
//   reset_n         synchronous active-low reset
//   lookup_valid    one-cycle pulse, lookup_tag is valid (ignored while busy)
//   lookup_tag      page tag of the CPU access
//   invalidate_all  one-cycle pulse, clear all valid bits (deferred if busy)
//   lookup_done     one-cycle pulse, lookup resolved
//   lookup_hit      with lookup_done: 1 = hit, 0 = resolved by a fill
//   lookup_page     with lookup_done: page now holding the tag
//   rdy             CPU ready; low from miss detection until fill commit
//   busy            high whenever the controller is not idle
//   mem_req/addr    byte read request to backing memory, {tag, offset}
//   mem_ack/data    response strobe and byte
//   fill_we/page/offset/data   write port into the cache page RAM
//
// Memory handshake: mem_req is held high for the whole fill and mem_addr is
// stable until mem_ack; each mem_ack (one cycle) completes the byte at the
// current mem_addr, after which mem_addr advances. Acks are only honoured in
// FILL. Each accepted ack produces exactly one fill_we on the next cycle.
// ---------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter  int ADDR_W    = 24,
  parameter  int PAGE_BITS = 8,
  localparam int TAG_W     = ADDR_W - PAGE_BITS
) (
  input  logic                 fpga,
  input  logic                 reset_n,
  input  logic                 lookup_valid,
  input  logic [TAG_W-1:0]     lookup_tag,
  input  logic                 invalidate_all,
  output logic                 lookup_done,
  output logic                 lookup_hit,
  output logic [1:0]           lookup_page,
  output logic                 rdy,
  output logic                 busy,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_data,
  output logic                 fill_we,
  output logic [1:0]           fill_page,
  output logic [PAGE_BITS-1:0] fill_offset,
  output logic [7:0]           fill_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_FILL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // Packed per-page ages; age 0 = most recently used, 3 = LRU.
  typedef logic [3:0][1:0] ages_t;
  localparam ages_t AGE_INIT = {2'd3, 2'd2, 2'd1, 2'd0};

  state_t               state;
  state_t               state_nxt;
  logic [TAG_W-1:0]     tag_r;
  logic [TAG_W-1:0]     tags [4];
  logic [3:0]           valid;
  ages_t                age;
  logic                 inv_pend;
  logic [1:0]           victim;
  logic [PAGE_BITS-1:0] offset;

  logic                 hit_any;
  logic [1:0]           hit_page;
  logic [1:0]           victim_sel;
  logic                 have_invalid;
  logic                 last_ack;

  // Touch page p: everything younger than p ages by one, p becomes youngest.
  // Keeps the ages a permutation of 0..3.
  function automatic ages_t touch(input ages_t a, input logic [1:0] p);
    ages_t r;
    for (int i = 0; i < 4; i++) begin
      r[i] = (a[i] < a[p]) ? a[i] + 2'd1 : a[i];
    end
    r[p] = 2'd0;
    return r;
  endfunction

  // Tag compare; tags are unique among valid pages so at most one matches.
  always_comb begin
    hit_any  = 1'b0;
    hit_page = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (valid[i] && (tags[i] == tag_r)) begin
        hit_any  = 1'b1;
        hit_page = 2'(i);
      end
    end
  end

  // Victim: lowest-index invalid page, otherwise the page whose age is 3.
  always_comb begin
    victim_sel   = 2'd0;
    have_invalid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_sel   = 2'(i);
        have_invalid = 1'b1;
      end
    end
    if (!have_invalid) begin
      for (int i = 0; i < 4; i++) begin
        if (age[i] == 2'd3) victim_sel = 2'(i);
      end
    end
  end

  assign last_ack = mem_ack && (offset == {PAGE_BITS{1'b1}});

  // State register
  always_ff @(posedge fpga) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (lookup_valid) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = hit_any ? S_IDLE : S_FILL;
      S_FILL:   if (last_ack) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; mem_addr is zero outside a fill.
  always_comb begin
    busy     = (state != S_IDLE);
    mem_req  = (state == S_FILL);
    mem_addr = '0;
    if (state == S_FILL) mem_addr = {tag_r, offset};
  end

  // Datapath, tag/valid/LRU array and registered outputs
  always_ff @(posedge fpga) begin
    if (!reset_n) begin
      tag_r       <= '0;
      for (int i = 0; i < 4; i++) tags[i] <= '0;
      valid       <= '0;
      age         <= AGE_INIT;
      inv_pend    <= 1'b0;
      victim      <= 2'd0;
      offset      <= '0;
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_page <= 2'd0;
      rdy         <= 1'b1;
      fill_we     <= 1'b0;
      fill_page   <= 2'd0;
      fill_offset <= '0;
      fill_data   <= 8'd0;
    end else begin
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_page <= 2'd0;
      fill_we     <= 1'b0;

      // An invalidate while busy is remembered and applied on the first idle
      // cycle, so it also covers a page committed in the meantime.
      if (invalidate_all && (state != S_IDLE)) inv_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          // Invalidate is applied in the same cycle a lookup is accepted, so
          // that lookup sees an empty cache.
          if (invalidate_all || inv_pend) begin
            valid    <= '0;
            age      <= AGE_INIT;
            inv_pend <= 1'b0;
          end
          if (lookup_valid) tag_r <= lookup_tag;
        end
        S_CHECK: begin
          if (hit_any) begin
            lookup_done <= 1'b1;
            lookup_hit  <= 1'b1;
            lookup_page <= hit_page;
            age         <= touch(age, hit_page);
          end else begin
            victim             <= victim_sel;
            valid[victim_sel]  <= 1'b0;
            rdy                <= 1'b0;
            offset             <= '0;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            fill_we     <= 1'b1;
            fill_page   <= victim;
            fill_offset <= offset;
            fill_data   <= mem_data;
            // Wraps to zero on the final byte, as the fill moves to COMMIT.
            offset      <= offset + PAGE_BITS'(1);
          end
        end
        S_COMMIT: begin
          tags[victim]  <= tag_r;
          valid[victim] <= 1'b1;
          age           <= touch(age, victim);
          lookup_done   <= 1'b1;
          lookup_page   <= victim;
          rdy           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;

  localparam int ADDR_W    = 24;
  localparam int PAGE_BITS = 8;
  localparam int TAG_W     = ADDR_W - PAGE_BITS;

  // ---------------- clock / reset ----------------
  logic                 fpga = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 lookup_valid = 1'b0;
  logic [TAG_W-1:0]     lookup_tag = '0;
  logic                 invalidate_all = 1'b0;
  logic                 mem_ack = 1'b0;
  logic [7:0]           mem_data = 8'd0;
  logic                 lookup_done;
  logic                 lookup_hit;
  logic [1:0]           lookup_page;
  logic                 rdy;
  logic                 busy;
  logic                 mem_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 fill_we;
  logic [1:0]           fill_page;
  logic [PAGE_BITS-1:0] fill_offset;
  logic [7:0]           fill_data;

  always #5 fpga = ~fpga;

  int cyc = 0;
  always @(posedge fpga) cyc <= cyc + 1;

  cache_fill_ctrl #(.ADDR_W(ADDR_W), .PAGE_BITS(PAGE_BITS)) dut (
    .fpga           (fpga),
    .reset_n        (reset_n),
    .lookup_valid   (lookup_valid),
    .lookup_tag     (lookup_tag),
    .invalidate_all (invalidate_all),
    .lookup_done    (lookup_done),
    .lookup_hit     (lookup_hit),
    .lookup_page    (lookup_page),
    .rdy            (rdy),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .fill_we        (fill_we),
    .fill_page      (fill_page),
    .fill_offset    (fill_offset),
    .fill_data      (fill_data)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       hit;
    logic [1:0] page;
    int         issue;
  } look_t;

  typedef struct {
    logic [1:0] page;
    logic [7:0] off;
    logic [7:0] data;
  } fill_t;

  look_t             look_q[$];
  logic [ADDR_W-1:0] exp_q[$];   // expected memory beat addresses, in order
  fill_t             fill_q[$];

  // Cache model: per-page valid/tag plus a recency list (front = most recent).
  logic              m_valid [4];
  logic [TAG_W-1:0]  m_tag   [4];
  int                m_order[$];
  bit                m_pend = 1'b0;

  bit chk_en    = 1'b0;
  bit resp_en   = 1'b1;
  bit stray_ack = 1'b0;
  int max_delay = 0;
  int wait_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_invalidate();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_order = '{0, 1, 2, 3};
  endfunction

  function automatic void model_reset();
    model_invalidate();
    for (int i = 0; i < 4; i++) m_tag[i] = '0;
    m_pend = 1'b0;
  endfunction

  function automatic void model_touch(input int p);
    for (int i = 0; i < m_order.size(); i++) begin
      if (m_order[i] == p) begin
        m_order.delete(i);
        break;
      end
    end
    m_order.push_front(p);
  endfunction

  function automatic void flush_all();
    look_q.delete();
    exp_q.delete();
    fill_q.delete();
  endfunction

  // ---------------- memory responder ----------------
  // Acks the current beat after 0..max_delay wait cycles; data = addr[7:0]^0x5A.
  initial begin
    forever begin
      @(posedge fpga); #1;
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_data  = 8'hEE;
        stray_ack = 1'b0;
      end else if (!resp_en) begin
        wait_left = 0;
      end else if (mem_req) begin
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_data  = mem_addr[7:0] ^ 8'h5A;
          wait_left = $urandom_range(max_delay, 0);
        end else begin
          wait_left--;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  look_t             ce;
  fill_t             cf;
  logic [ADDR_W-1:0] ca;

  always @(negedge fpga) begin
    if (chk_en) begin
      if (mem_req) begin
        check("req_rdy_low", rdy, 1'b0);
        check("req_busy", busy, 1'b1);
        check("req_only_on_miss", exp_q.size() != 0, 1'b1);
      end
      if (mem_ack && mem_req) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          ca = exp_q.pop_front();
          check("mem_addr", mem_addr, ca);
        end
      end
      if (fill_we) begin
        check("fill_expected", fill_q.size() != 0, 1'b1);
        if (fill_q.size() != 0) begin
          cf = fill_q.pop_front();
          check("fill_page", fill_page, cf.page);
          check("fill_offset", fill_offset, cf.off);
          check("fill_data", fill_data, cf.data);
        end
      end
      if (lookup_done) begin
        check("done_expected", look_q.size() != 0, 1'b1);
        if (look_q.size() != 0) begin
          ce = look_q.pop_front();
          check("lookup_hit", lookup_hit, ce.hit);
          check("lookup_page", lookup_page, ce.page);
          if (ce.hit) begin
            check("hit_latency", cyc - ce.issue, 2);
          end else begin
            check("miss_not_at_n2", (cyc - ce.issue) > 2, 1'b1);
            check("beats_left", exp_q.size(), 0);
            check("fills_left", fill_q.size(), 0);
          end
          if (m_pend) begin
            model_invalidate();
            m_pend = 1'b0;
          end
        end
      end
      if (look_q.size() == 0) begin
        check("idle_rdy", rdy, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_req", mem_req, 1'b0);
      end else if (look_q[0].hit) begin
        check("hit_rdy", rdy, 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fpga); #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    step(cycles);
    check("rst_lookup_done", lookup_done, 1'b0);
    check("rst_lookup_hit", lookup_hit, 1'b0);
    check("rst_lookup_page", lookup_page, 2'd0);
    check("rst_rdy", rdy, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 24'd0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_fill_page", fill_page, 2'd0);
    check("rst_fill_offset", fill_offset, 8'd0);
    check("rst_fill_data", fill_data, 8'd0);
    reset_n = 1'b1;
    flush_all();
    model_reset();
    chk_en = 1'b1;
  endtask

  // Issue a lookup (optionally together with invalidate_all). The model
  // predicts the result; the literal lit_hit/lit_page pin the prediction.
  task automatic lookup(input logic [TAG_W-1:0] t, input bit with_inv,
                        input logic lit_hit, input logic [1:0] lit_page);
    logic  h;
    int    p;
    int    v;
    look_t e;
    fill_t f;
    if (with_inv) model_invalidate();
    h = 1'b0;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_tag[i] == t) begin
        h = 1'b1;
        p = i;
      end
    end
    if (!h) begin
      v = -1;
      for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) v = m_order[3];
      p = v;
      m_tag[p]   = t;
      m_valid[p] = 1'b1;
      for (int o = 0; o < 256; o++) begin
        exp_q.push_back({t, 8'(o)});
        f.page = 2'(p);
        f.off  = 8'(o);
        f.data = 8'(o) ^ 8'h5A;
        fill_q.push_back(f);
      end
    end
    model_touch(p);
    check("model_hit", h, lit_hit);
    check("model_page", p, lit_page);
    e.hit   = h;
    e.page  = 2'(p);
    e.issue = cyc;
    look_q.push_back(e);
    lookup_valid   = 1'b1;
    lookup_tag     = t;
    invalidate_all = with_inv;
    step(1);
    lookup_valid   = 1'b0;
    invalidate_all = 1'b0;
  endtask

  task automatic pulse_invalidate();
    if (look_q.size() != 0) m_pend = 1'b1;
    else                    model_invalidate();
    invalidate_all = 1'b1;
    step(1);
    invalidate_all = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (look_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("done_within_budget", look_q.size() == 0, 1'b1);
    if (look_q.size() != 0) flush_all();
  endtask

  task automatic wait_offset(input logic [7:0] o, input int budget);
    int n = 0;
    while (!(mem_req && mem_addr[7:0] == o) && n < budget) begin
      step(1);
      n++;
    end
    check("reach_offset", mem_req && mem_addr[7:0] == o, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset(3);

    // 1: cold miss fills page 0 with 256 in-order beats
    max_delay = 0;
    lookup(16'h1234, 1'b0, 1'b0, 2'd0);
    wait_done(2000);

    // 2: same tag hits page 0 with no memory traffic
    lookup(16'h1234, 1'b0, 1'b1, 2'd0);
    wait_done(20);
    step(2);

    // stray ack while idle must produce no fill write
    stray_ack = 1'b1;
    step(6);

    // 3: LRU replacement
    do_reset(2);
    lookup(16'h0001, 1'b0, 1'b0, 2'd0); wait_done(2000);
    lookup(16'h0002, 1'b0, 1'b0, 2'd1); wait_done(2000);
    lookup(16'h0003, 1'b0, 1'b0, 2'd2); wait_done(2000);
    lookup(16'h0004, 1'b0, 1'b0, 2'd3); wait_done(2000);
    lookup(16'h0001, 1'b0, 1'b1, 2'd0); wait_done(20);
    lookup(16'h0005, 1'b0, 1'b0, 2'd1); wait_done(2000);
    lookup(16'h0002, 1'b0, 1'b0, 2'd2); wait_done(2000);
    lookup(16'h0004, 1'b0, 1'b1, 2'd3); wait_done(20);

    // 4: random memory latency; LRU victim is now page 0
    max_delay = 5;
    lookup(16'h00AB, 1'b0, 1'b0, 2'd0);
    wait_done(4000);

    // 5: invalidate mid-fill is deferred until after commit
    max_delay = 2;
    lookup(16'h0BEE, 1'b0, 1'b0, 2'd1);
    wait_offset(8'h80, 2000);
    pulse_invalidate();
    wait_done(3000);
    step(2);
    lookup(16'h0BEE, 1'b0, 1'b0, 2'd0);
    wait_done(3000);
    // lookup together with invalidate: invalidate first, so it misses
    lookup(16'h0BEE, 1'b1, 1'b0, 2'd0);
    wait_done(3000);

    // 6: reset mid-fill aborts; a lookup while busy is ignored
    max_delay = 1;
    lookup(16'h0777, 1'b0, 1'b0, 2'd1);
    step(5);
    lookup_valid = 1'b1;
    lookup_tag   = 16'h0777;
    step(1);
    lookup_valid = 1'b0;
    wait_offset(8'h40, 2000);
    resp_en = 1'b0;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_rdy", rdy, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_lookup_done", lookup_done, 1'b0);
    flush_all();
    model_reset();
    resp_en = 1'b1;
    chk_en  = 1'b1;
    step(20);
    lookup(16'h0777, 1'b0, 1'b0, 2'd0);
    wait_done(3000);
    step(5);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Controller that sequences the 4-page CPU cache.
- Owns the page tag/valid array and true-LRU replacement state.
- Resolves lookups issued by the cache datapath; on a miss it stalls the CPU through rdy and burst-fills the victim page from backing memory over a req/ack byte handshake.
- Runs entirely in the fpga clock domain.

Parameters:
ADDR_W, 24, full CPU address width (bank byte + 16-bit address)
PAGE_BITS, 8, log2 of page size in bytes; tag width TAG_W = ADDR_W-PAGE_BITS

Ports:
fpga  in  1  system clock (all logic on rising edge)
reset_n  in  1  synchronous active-low reset
lookup_valid  in  1  one-cycle pulse: lookup_tag is valid
lookup_tag  in  TAG_W  page tag of CPU access (Addr[ADDR_W-1:PAGE_BITS])
invalidate_all  in  1  one-cycle pulse: clear all valid bits
lookup_done  out  1  one-cycle pulse: lookup resolved
lookup_hit  out  1  with lookup_done: 1 = hit, 0 = resolved by fill
lookup_page  out  2  with lookup_done: page index holding the tag
rdy  out  1  CPU ready; low from miss detection until fill commit
busy  out  1  high whenever state != IDLE
mem_req  out  1  byte read request to backing memory
mem_addr  out  ADDR_W  byte address, {fill tag, fill offset}
mem_ack  in  1  one-cycle pulse: mem_data valid for current mem_addr
mem_data  in  8  read data
fill_we  out  1  write strobe into cache page RAM
fill_page  out  2  destination page
fill_offset  out  PAGE_BITS  destination byte offset
fill_data  out  8  byte to write

Behaviour:
- Reset (reset_n low at rising edge):
  - state=IDLE; all outputs 0 except rdy=1.
  - valid[3:0]=0, tags=0, age[i]=i, invalidate-pending flag=0.
  - Aborts any fill in progress: mem_req low the cycle after the reset edge.
- States: IDLE, CHECK, FILL, COMMIT.
- IDLE:
  - On lookup_valid, register lookup_tag and go to CHECK.
  - Otherwise, if invalidate_all or the pending flag is set, clear valid[3:0], reset age[i]=i, clear the flag.
  - If lookup_valid and invalidate_all arrive together, the invalidate applies first, so the lookup misses.
- CHECK:
  - Compare the registered tag against all valid pages; at most one can match.
  - Hit: the next edge drives lookup_done=1, lookup_hit=1, lookup_page=p, touches p in LRU, and returns to IDLE. Latency is lookup_valid in cycle N to lookup_done in cycle N+2.
  - Miss: victim is the lowest-index invalid page; if all are valid, the page with age==3. Then clear valid[victim], rdy<=0, offset<=0, go to FILL.
- FILL:
  - mem_req=1, mem_addr={tag, offset}; req stays high until the final ack.
  - On each mem_ack: next cycle fill_we=1, fill_page=victim, fill_offset=offset, fill_data=mem_data; offset increments with the ack.
  - Ack at offset = 2^PAGE_BITS-1 goes to COMMIT, and mem_req drops the cycle after that ack.
  - mem_ack outside FILL is ignored.
- COMMIT (one cycle, coincides with the last fill_we):
  - tag[victim]<=tag, valid[victim]<=1, touch victim.
  - Drive lookup_done=1, lookup_hit=0, lookup_page=victim, rdy<=1, go to IDLE.
- LRU update (touch p): every page with age < age[p] increments, then age[p]=0. Ages always form a permutation of 0..3.
- lookup_valid while busy=1 is ignored; the cache must wait for lookup_done.
- invalidate_all while busy sets the pending flag. The flag is serviced on the first IDLE cycle, so the just-committed page is invalidated too.
- Offset counter is PAGE_BITS wide; its wrap from the maximum value to 0 coincides with COMMIT.
- No fill_we is ever issued without a matching prior mem_ack.

Test Plan:
1. Reset, then lookup_tag=0x1234 → lookup_done not asserted at N+2. Then exactly 256 mem_req beats at mem_addr 0x123400..0x1234FF in order, 256 fill_we to page 0 at offsets 0x00..0xFF. Finally lookup_done with hit=0, page=0, and rdy back to 1.
2. Repeat lookup 0x1234 → lookup_done at N+2, hit=1, page=0, no mem_req, rdy stays 1.
3. Fill tags 0x0001/0x0002/0x0003/0x0004 into pages 0-3, hit 0x0001, then miss 0x0005 → victim page 1; a subsequent lookup of 0x0002 misses.
4. Random mem_ack delay of 0-5 cycles with mem_data = mem_addr[7:0]^0x5A → every fill_data/fill_offset pair matches; rdy is low for the whole fill.
5. invalidate_all pulsed mid-fill at offset 0x80 → fill completes and lookup_done fires, then all valid bits clear in the next IDLE cycle; relookup of the same tag misses into page 0.
6. reset_n low for one cycle during fill at offset 0x40 → next cycle mem_req=0, rdy=1, busy=0. A lookup_valid pulsed while busy (before the reset) produced no extra lookup_done.
